// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
// The instruction-memory model and the control unit use the same next-PC codes,
// the same enable value and the same bubble encoding.
package fetch_stage_pkg;

   localparam logic [31:0] START_ADDRESS_DEFAULT = 32'h0000_3000;

   typedef enum logic [1:0] {
      NPC_SEL_PC4    = 2'd0,
      NPC_SEL_BRANCH = 2'd1,
      NPC_SEL_JUMP   = 2'd2,
      NPC_SEL_JR     = 2'd3
   } npc_sel_t;

   localparam logic IM_ENABLE = 1'b1;

   localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
   localparam logic [31:0] BUBBLE_PC    = 32'h0000_0000;
   localparam logic [31:0] BUBBLE_PC8   = 32'h0000_0000;
   localparam logic        BUBBLE_VALID = 1'b0;
   localparam logic        BUBBLE_EXC   = 1'b0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic        valid;
      logic        exc;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{
      instr : BUBBLE_INSTR,
      pc    : BUBBLE_PC,
      pc8   : BUBBLE_PC8,
      valid : BUBBLE_VALID,
      exc   : BUBBLE_EXC
   };

endpackage

// File: rtl/fetch_stage_npc.sv
// Next-PC selection for the fetch stage.
// Jumps take their upper nibble from the PC of the instruction in decode,
// because that is the jump itself and the current fetch is its delay slot.
module fetch_stage_npc
   import fetch_stage_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [3:0]  i_ifIdPcTop,
   input  logic [1:0]  i_npcSel,
   input  logic [31:0] i_branchTarget,
   input  logic [25:0] i_jumpIndex,
   input  logic [31:0] i_jrTarget,
   output logic [31:0] o_npc
);

   // Pick the next fetch address; jr targets pass through untouched so a
   // misaligned register value surfaces as a fetch exception one cycle later
   always_comb begin
      o_npc = i_pc + 32'd4;
      case (npc_sel_t'(i_npcSel))
         NPC_SEL_PC4:    o_npc = i_pc + 32'd4;
         NPC_SEL_BRANCH: o_npc = i_branchTarget;
         NPC_SEL_JUMP:   o_npc = {i_ifIdPcTop, i_jumpIndex, 2'b00};
         NPC_SEL_JR:     o_npc = i_jrTarget;
         default:        o_npc = i_pc + 32'd4;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and loads the IF/ID pipeline register. Out-of-range or misaligned
// fetches are only flagged; vectoring to a handler happens further down the pipe.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] START_ADDRESS = START_ADDRESS_DEFAULT,
   parameter int          IM_SIZE       = 1024
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [1:0]  npc_sel,
   input  logic [31:0] branch_target,
   input  logic [25:0] jump_index,
   input  logic [31:0] jr_target,
   output logic [31:0] im_addr,
   output logic        im_enable,
   input  logic [31:0] im_result,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc8,
   output logic        if_id_valid,
   output logic        if_id_exc
);

   // Range limits kept at 33 bits so the end address cannot wrap
   localparam logic [32:0] LOW_LIMIT  = {1'b0, START_ADDRESS};
   localparam logic [32:0] HIGH_LIMIT = {1'b0, START_ADDRESS} + 33'(4 * IM_SIZE);

   logic [31:0] r_pc;
   if_id_t      r_ifId;
   if_id_t      w_ifIdNext;
   logic [31:0] w_npc;
   logic        w_fetchExc;

   fetch_stage_npc u_npc (
      .i_pc           (r_pc),
      .i_ifIdPcTop    (r_ifId.pc[31:28]),
      .i_npcSel       (npc_sel),
      .i_branchTarget (branch_target),
      .i_jumpIndex    (jump_index),
      .i_jrTarget     (jr_target),
      .o_npc          (w_npc)
   );

   assign im_addr   = r_pc;
   assign im_enable = IM_ENABLE;

   // Flag the current fetch address and build the IF/ID word; a faulting fetch
   // carries a nop so nothing the memory returns can reach decode
   always_comb begin
      w_fetchExc = (r_pc[1:0] != 2'b00)
                || ({1'b0, r_pc} <  LOW_LIMIT)
                || ({1'b0, r_pc} >= HIGH_LIMIT);
      w_ifIdNext       = IF_ID_BUBBLE;
      w_ifIdNext.instr = w_fetchExc ? BUBBLE_INSTR : im_result;
      w_ifIdNext.pc    = r_pc;
      w_ifIdNext.pc8   = r_pc + 32'd8;
      w_ifIdNext.valid = 1'b1;
      w_ifIdNext.exc   = w_fetchExc;
   end

   // PC and IF/ID update: stall freezes the PC, flush wins over stall for the
   // pipeline register so a squashed slot never lingers in decode
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc   <= START_ADDRESS;
         r_ifId <= IF_ID_BUBBLE;
      end else begin
         if (!stall) begin
            r_pc <= w_npc;
         end
         if (flush) begin
            r_ifId <= IF_ID_BUBBLE;
         end else if (!stall) begin
            r_ifId <= w_ifIdNext;
         end
      end
   end

   assign if_id_instr = r_ifId.instr;
   assign if_id_pc    = r_ifId.pc;
   assign if_id_pc8   = r_ifId.pc8;
   assign if_id_valid = r_ifId.valid;
   assign if_id_exc   = r_ifId.exc;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized run, all
// checked against a behavioural model of the fetch stage and its memory.
module tb_fetch_stage;

   localparam logic [31:0] START   = 32'h0000_3000;
   localparam int          IM_SIZE = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [1:0]  npcSel;
   logic [31:0] branchTarget;
   logic [25:0] jumpIndex;
   logic [31:0] jrTarget;
   logic [31:0] imAddr;
   logic        imEnable;
   logic [31:0] imResult;
   logic [31:0] ifIdInstr;
   logic [31:0] ifIdPc;
   logic [31:0] ifIdPc8;
   logic        ifIdValid;
   logic        ifIdExc;

   logic [31:0] mem [IM_SIZE];

   logic [31:0] mPc;
   logic [31:0] mInstr;
   logic [31:0] mIfPc;
   logic [31:0] mPc8;
   logic        mValid;
   logic        mExc;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.START_ADDRESS(START), .IM_SIZE(IM_SIZE)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .flush         (flush),
      .npc_sel       (npcSel),
      .branch_target (branchTarget),
      .jump_index    (jumpIndex),
      .jr_target     (jrTarget),
      .im_addr       (imAddr),
      .im_enable     (imEnable),
      .im_result     (imResult),
      .if_id_instr   (ifIdInstr),
      .if_id_pc      (ifIdPc),
      .if_id_pc8     (ifIdPc8),
      .if_id_valid   (ifIdValid),
      .if_id_exc     (ifIdExc)
   );

   always #5 clk = ~clk;

   // Instruction memory: word-indexed, zero outside its window
   function automatic logic [31:0] memRead(input logic [31:0] addr);
      longint a;
      a = longint'(addr);
      if (a >= longint'(START) && a < longint'(START) + 4 * IM_SIZE)
         return mem[int'((a - longint'(START)) / 4)];
      return 32'h0;
   endfunction

   function automatic logic addrFaults(input logic [31:0] addr);
      longint a;
      a = longint'(addr);
      return (a % 4 != 0) || (a < longint'(START)) || (a >= longint'(START) + 4 * IM_SIZE);
   endfunction

   function automatic logic [130:0] dutVec();
      return {imAddr, ifIdInstr, ifIdPc, ifIdPc8, ifIdValid, ifIdExc, imEnable};
   endfunction

   function automatic logic [130:0] modelVec();
      return {mPc, mInstr, mIfPc, mPc8, mValid, mExc, 1'b1};
   endfunction

   // One clock edge: the model applies the stage's rules to the inputs
   // currently driven, then outputs are sampled 1 time unit after the edge
   task automatic applyStimulus();
      logic [31:0] target;
      logic [31:0] nPc;
      logic [31:0] nInstr, nIfPc, nPc8;
      logic        nValid, nExc;
      case (npcSel)
         2'd0:    target = mPc + 32'd4;
         2'd1:    target = branchTarget;
         2'd2:    target = {mIfPc[31:28], jumpIndex, 2'b00};
         default: target = jrTarget;
      endcase
      nPc = mPc; nInstr = mInstr; nIfPc = mIfPc; nPc8 = mPc8; nValid = mValid; nExc = mExc;
      if (reset) begin
         nPc = START; nInstr = 0; nIfPc = 0; nPc8 = 0; nValid = 0; nExc = 0;
      end else begin
         if (!stall) nPc = target;
         if (flush) begin
            nInstr = 0; nIfPc = 0; nPc8 = 0; nValid = 0; nExc = 0;
         end else if (!stall) begin
            nExc   = addrFaults(mPc);
            nInstr = nExc ? 32'h0 : memRead(mPc);
            nIfPc  = mPc;
            nPc8   = mPc + 32'd8;
            nValid = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      mPc = nPc; mInstr = nInstr; mIfPc = nIfPc; mPc8 = nPc8; mValid = nValid; mExc = nExc;
   endtask

   function automatic logic [31:0] randTarget();
      case ($urandom_range(0, 5))
         0:       return START + 32'($urandom_range(0, IM_SIZE - 1) * 4) + 32'($urandom_range(1, 3));
         1:       return $urandom();
         2:       return START - 32'd4;
         3:       return START + 32'(4 * IM_SIZE);
         default: return START + 32'($urandom_range(0, IM_SIZE - 1) * 4);
      endcase
   endfunction

   task automatic test_reset();
      reset = 1; stall = 1; flush = 1; npcSel = 2'd1;
      branchTarget = 32'h0000_5000; jumpIndex = 26'h0; jrTarget = 32'h0;
      applyStimulus();
      applyStimulus();
      checks++;
      if (imAddr !== 32'h0000_3000) begin
         errors++; $display("FAIL reset_pc actual=%h expected=%h", imAddr, 32'h0000_3000);
      end
      checks++;
      if ({ifIdInstr, ifIdPc, ifIdPc8, ifIdValid, ifIdExc} !== 98'h0) begin
         errors++; $display("FAIL reset_ifid actual=%h_%h_%h_%b_%b expected=all zero", ifIdInstr, ifIdPc, ifIdPc8, ifIdValid, ifIdExc);
      end
      checks++;
      if (imEnable !== 1'b1) begin
         errors++; $display("FAIL reset_enable actual=%b expected=1", imEnable);
      end
      reset = 0; stall = 0; flush = 0; npcSel = 2'd0;
   endtask

   task automatic test_sequential();
      applyStimulus();
      checks++;
      if ({imAddr, ifIdInstr, ifIdPc, ifIdPc8, ifIdValid} !== {32'h3004, 32'h3C010001, 32'h3000, 32'h3008, 1'b1}) begin
         errors++; $display("FAIL seq_first actual=%h %h %h %h %b expected=3004 3c010001 3000 3008 1", imAddr, ifIdInstr, ifIdPc, ifIdPc8, ifIdValid);
      end
      applyStimulus();
      checks++;
      if ({imAddr, ifIdInstr, ifIdPc, ifIdValid} !== {32'h3008, 32'h34210002, 32'h3004, 1'b1}) begin
         errors++; $display("FAIL seq_second actual=%h %h %h %b expected=3008 34210002 3004 1", imAddr, ifIdInstr, ifIdPc, ifIdValid);
      end
   endtask

   task automatic test_stall();
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         checks++;
         if ({imAddr, ifIdInstr, ifIdPc} !== {32'h3008, 32'h34210002, 32'h3004}) begin
            errors++; $display("FAIL stall_hold%0d actual=%h %h %h expected=3008 34210002 3004", i, imAddr, ifIdInstr, ifIdPc);
         end
      end
      stall = 0;
      applyStimulus();
      checks++;
      if ({imAddr, ifIdInstr, ifIdPc, ifIdValid} !== {32'h300C, 32'h0, 32'h3008, 1'b1}) begin
         errors++; $display("FAIL stall_release actual=%h %h %h %b expected=300c 0 3008 1", imAddr, ifIdInstr, ifIdPc, ifIdValid);
      end
   endtask

   task automatic test_jump();
      npcSel = 2'd1; branchTarget = 32'h3010;
      applyStimulus();
      npcSel = 2'd0;
      applyStimulus();
      checks++;
      if (ifIdPc !== 32'h3010) begin
         errors++; $display("FAIL jump_setup actual=%h expected=3010", ifIdPc);
      end
      npcSel = 2'd2; jumpIndex = 26'h0000C10;
      applyStimulus();
      checks++;
      if (imAddr !== 32'h0000_3040) begin
         errors++; $display("FAIL jump_target actual=%h expected=00003040", imAddr);
      end
      npcSel = 2'd0;
   endtask

   task automatic test_jr_exc();
      logic [31:0] targets [5] = '{32'h3002, 32'h2FFC, 32'h4000, 32'h3FFC, 32'h3000};
      logic        expExc  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] expInstr;
      for (int i = 0; i < 5; i++) begin
         npcSel = 2'd3; jrTarget = targets[i];
         applyStimulus();
         npcSel = 2'd0;
         applyStimulus();
         expInstr = expExc[i] ? 32'h0 : memRead(targets[i]);
         checks++;
         if ({ifIdExc, ifIdInstr, ifIdPc, ifIdValid} !== {expExc[i], expInstr, targets[i], 1'b1}) begin
            errors++; $display("FAIL jr_exc_%h actual=%b %h %h %b expected=%b %h %h 1", targets[i], ifIdExc, ifIdInstr, ifIdPc, ifIdValid, expExc[i], expInstr, targets[i]);
         end
      end
   endtask

   task automatic test_wrap();
      npcSel = 2'd3; jrTarget = 32'hFFFF_FFFC;
      applyStimulus();
      npcSel = 2'd0;
      applyStimulus();
      checks++;
      if ({imAddr, ifIdPc, ifIdPc8, ifIdExc} !== {32'h0, 32'hFFFF_FFFC, 32'h4, 1'b1}) begin
         errors++; $display("FAIL wrap actual=%h %h %h %b expected=0 fffffffc 4 1", imAddr, ifIdPc, ifIdPc8, ifIdExc);
      end
   endtask

   task automatic test_stall_flush();
      npcSel = 2'd1; branchTarget = 32'h3020;
      applyStimulus();
      npcSel = 2'd0; stall = 1; flush = 1;
      applyStimulus();
      checks++;
      if ({imAddr, ifIdValid, ifIdInstr, ifIdPc, ifIdPc8, ifIdExc} !== {32'h3020, 1'b0, 96'h0, 1'b0}) begin
         errors++; $display("FAIL stall_flush actual=%h %b %h %h %h %b expected=3020 bubble", imAddr, ifIdValid, ifIdInstr, ifIdPc, ifIdPc8, ifIdExc);
      end
      stall = 0;
      applyStimulus();
      checks++;
      if ({imAddr, ifIdValid, ifIdInstr, ifIdPc} !== {32'h3024, 1'b0, 64'h0}) begin
         errors++; $display("FAIL flush_only actual=%h %b %h %h expected=3024 bubble", imAddr, ifIdValid, ifIdInstr, ifIdPc);
      end
      flush = 0;
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
         stall        = ($urandom_range(0, 3) == 0);
         flush        = ($urandom_range(0, 5) == 0);
         npcSel       = 2'($urandom_range(0, 3));
         branchTarget = randTarget();
         jrTarget     = randTarget();
         jumpIndex    = ($urandom_range(0, 1) == 0) ? 26'($urandom()) : 26'((START >> 2) + 32'($urandom_range(0, IM_SIZE - 1)));
         if ($urandom_range(0, 2) != 0 && npcSel != 2'd0) npcSel = 2'd0;
         applyStimulus();
         checks++;
         if (dutVec() !== modelVec()) begin
            errors++; bad++;
            if (bad <= 10) $display("FAIL random_%0d actual=%h expected=%h", i, dutVec(), modelVec());
         end
      end
      stall = 0; flush = 0; npcSel = 2'd0;
   endtask

   task automatic test_reset_midrun();
      npcSel = 2'd1; branchTarget = 32'h3040;
      applyStimulus();
      checks++;
      if (imAddr !== 32'h3040) begin
         errors++; $display("FAIL midrun_setup actual=%h expected=3040", imAddr);
      end
      reset = 1; stall = 1; npcSel = 2'd1; branchTarget = 32'h0000_5000;
      applyStimulus();
      checks++;
      if ({imAddr, ifIdInstr, ifIdPc, ifIdPc8, ifIdValid, ifIdExc} !== {32'h3000, 98'h0}) begin
         errors++; $display("FAIL midrun_reset actual=%h %h %h %h %b %b expected=3000 zeros", imAddr, ifIdInstr, ifIdPc, ifIdPc8, ifIdValid, ifIdExc);
      end
      reset = 0; stall = 0; npcSel = 2'd0;
   endtask

   task automatic checkOutput();
      checks++;
      if (dutVec() !== modelVec()) begin
         errors++; $display("FAIL final_state actual=%h expected=%h", dutVec(), modelVec());
      end
   endtask

   assign imResult = memRead(imAddr);

   initial begin
      for (int i = 0; i < IM_SIZE; i++) mem[i] = $urandom();
      mem[0] = 32'h3C01_0001;
      mem[1] = 32'h3421_0002;
      mem[2] = 32'h0000_0000;
      mPc = 0; mInstr = 0; mIfPc = 0; mPc8 = 0; mValid = 0; mExc = 0;
      $display("[TB] fetch_stage bench starting");
      test_reset();
      test_sequential();
      test_stall();
      test_jump();
      test_jr_exc();
      test_wrap();
      test_stall_flush();
      test_random();
      test_reset_midrun();
      checkOutput();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Owns the PC register and drives the address and enable into the instruction memory. The memory is a combinational read: address in, 32-bit word out, zero below its start address.
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles sequential fetch, branch/jump/jr redirection, stall, flush and fetch-address exceptions.

Parameters:
- START_ADDRESS, 32'h0000_3000, reset PC; first word of instruction memory.
- IM_SIZE, 1024, instruction memory depth in 32-bit words. Valid fetch range is [START_ADDRESS, START_ADDRESS + 4*IM_SIZE).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC and IF/ID contents (from hazard unit)
- flush  input  1  replace the next IF/ID load with a bubble
- npc_sel  input  2  next-PC select from ID: 0=PC+4, 1=branch, 2=j/jal, 3=jr/jalr
- branch_target  input  32  fully computed branch target
- jump_index  input  26  instr_index field of j/jal held in ID
- jr_target  input  32  register value for jr/jalr
- im_addr  output  32  fetch address to instruction memory
- im_enable  output  1  instruction-memory enable
- im_result  input  32  word returned by instruction memory (same cycle)
- if_id_instr  output  32  registered instruction
- if_id_pc  output  32  registered PC of that instruction
- if_id_pc8  output  32  registered PC+8 (link value)
- if_id_valid  output  1  1 = real instruction, 0 = bubble
- if_id_exc  output  1  fetch-address exception flag for that instruction

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on the port named reset.
- Reset values:
  - pc = START_ADDRESS.
  - if_id_instr = 0, if_id_pc = 0, if_id_pc8 = 0.
  - if_id_valid = 0, if_id_exc = 0.
  - Reset overrides stall, flush and npc_sel.
- Memory interface (combinational):
  - im_addr = pc.
  - im_enable = IM_ENABLE, always asserted out of reset.
  - Memory read latency is 0, so the fetched word is available the same cycle.
- Next-PC calculation (npc):
  - 0: pc + 4, mod 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
  - 1: branch_target.
  - 2: {if_id_pc[31:28], jump_index, 2'b00}, using the ID-stage PC (delay-slot semantics).
  - 3: jr_target, used unmodified, no alignment forcing.
- Fetch exception:
  - fetch_exc = (pc[1:0] != 0) OR pc < START_ADDRESS OR pc >= START_ADDRESS + 4*IM_SIZE.
  - All comparisons are unsigned, 33-bit, so START_ADDRESS + 4*IM_SIZE cannot overflow.
  - When fetch_exc is set, the word loaded into IF/ID is 32'h0 (nop) regardless of im_result.
- Per-edge update when reset=0, in priority order:
  - stall=1, flush=0: pc and all IF/ID registers hold.
  - stall=1, flush=1: pc holds; IF/ID loads a bubble.
  - stall=0, flush=1: pc <= npc; IF/ID loads a bubble.
  - stall=0, flush=0: pc <= npc; IF/ID loads {instr, pc, pc+8, valid=1, exc=fetch_exc}.
- Bubble contents: instr = 0, pc = 0, pc8 = 0, valid = 0, exc = 0.
- Redirect timing: npc_sel is sampled every non-stalled edge. A redirect issued while the delay-slot instruction is in IF takes effect on that edge.
- No state machine beyond the PC and IF/ID registers. Exceptions are flagged only; the PC is never vectored here.
- Debug: on every PC change, emit one debug_write line with pc, fetch_exc and the fetched word.

Decomposition:
- Shared header fetch.h holds:
  - START_ADDRESS default.
  - NPC_SEL_PC4, NPC_SEL_BRANCH, NPC_SEL_JUMP, NPC_SEL_JR codes.
  - IM_ENABLE value.
  - The bubble constants.
- The constants are shared with the instruction-memory header and the control unit.
- One sub-module: npc. It is combinational and takes pc, if_id_pc, npc_sel, branch_target, jump_index and jr_target, returning npc.

Test Plan:
1. Reset then 3 free-running cycles, npc_sel=0, memory words 0x3C010001, 0x34210002, 0x00000000 → im_addr 0x3000, 0x3004, 0x3008. IF/ID gets instr 0x3C010001 with pc 0x3000 and pc8 0x3008, then 0x34210002, each with valid=1.
2. stall=1 for 2 cycles at pc=0x3008 → im_addr stays 0x3008 and IF/ID holds the 0x3004 instruction. After stall drops, pc advances to 0x300C.
3. if_id_pc=0x3010, npc_sel=2, jump_index=0x0000C10 → next pc = 0x0000_3040.
4. npc_sel=3, jr_target=0x3002 → next cycle if_id_exc=1, if_id_instr=0, if_id_pc=0x3002, valid=1. Repeat with jr_target=0x2FFC (below range) and 0x4000 (= START + 4*1024) → exc=1 for both.
5. stall=1 with flush=1 at pc=0x3020 → pc stays 0x3020 and IF/ID becomes a bubble (valid=0, instr=0). Then flush=1 alone → pc=0x3024 and the bubble is loaded again.
6. reset asserted mid-run at pc=0x3040 with stall=1 and npc_sel=1 → next edge pc=0x3000, all IF/ID outputs 0.
